// File: rtl/genit_stim_if.sv
// ---------------------------------------------------------------------------
// genit_stim_if
//
// Bundles the stimulus/check signals exchanged between genit_stim and the
// generate-loop regression harness it exercises. Clock and reset are not part
// of the bundle; they stay plain ports on the modules.
//
// Signals:
//   start            run request (one-cycle pulse) into genit_stim
//   result           harness output under check, into genit_stim
//   value            registered stimulus bit towards the harness
//   busy             high while a run is in WARMUP or RUN
//   done             high once a run has finished, until the next start
//   pass             done with zero mismatches
//   err_count        saturating mismatch count of the current/last run
//   first_err_cycle  RUN index of the first mismatch, 16'hFFFF if none
//
// Modports:
//   master  the genit_stim side (drives value and the status outputs)
//   slave   the harness / controller side
// ---------------------------------------------------------------------------
interface genit_stim_if #(
    parameter int ERR_W = 8
);
    logic             start;
    logic             result;
    logic             value;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_count;
    logic [15:0]      first_err_cycle;

    modport master (
        input  start,
        input  result,
        output value,
        output busy,
        output done,
        output pass,
        output err_count,
        output first_err_cycle
    );

    modport slave (
        output start,
        output result,
        input  value,
        input  busy,
        input  done,
        input  pass,
        input  err_count,
        input  first_err_cycle
    );
endinterface

// File: rtl/genit_stim.sv
// ---------------------------------------------------------------------------
// genit_stim
//
// Stimulus-and-check driver for the generate-loop regression harness.
// Drives a seeded 16-bit Fibonacci LFSR bit stream onto `value`, keeps a
// LATENCY-deep copy of what it drove, and compares the harness `result`
// against that delayed copy for NUM_CYCLES cycles. Reports a saturating
// mismatch count, the RUN index of the first mismatch and a pass verdict.
//
// Parameters:
//   LATENCY     cycles from value to the matching result (1..8)
//   NUM_CYCLES  compared cycles per run (1..65535)
//   SEED        LFSR load value (nonzero)
//   ERR_W       width of the mismatch counter
//
// Ports:
//   clk    sole clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    genit_stim_if master modport (start/result in, status out)
//
// Timing model: the FSM state leads the visible outputs by one cycle.
// value/busy/done and the compare enable are all registered from the state,
// so `busy` and the first stimulus bit appear one edge after `start` is
// taken, and `done` appears one cycle after the last compare.
// ---------------------------------------------------------------------------
module genit_stim #(
    parameter int          LATENCY    = 1,
    parameter int          NUM_CYCLES = 100,
    parameter logic [15:0] SEED       = 16'hACE1,
    parameter int          ERR_W      = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    genit_stim_if.master bus
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WARMUP = 2'd1;
    localparam logic [1:0] ST_RUN    = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic [15:0]      WARM_LAST = 16'(LATENCY - 1);
    localparam logic [15:0]      RUN_LAST  = 16'(NUM_CYCLES - 1);
    localparam logic [15:0]      NO_ERR    = 16'hFFFF;
    localparam logic [ERR_W-1:0] ERR_MAX   = '1;
    localparam logic [ERR_W-1:0] ERR_ONE   = ERR_W'(1);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [1:0]         state_q,     state_d;
    logic [15:0]        phase_q,     phase_d;
    logic [15:0]        lfsr_q,      lfsr_d;
    logic               value_q,     value_d;
    logic               busy_q,      busy_d;
    logic               done_q,      done_d;
    logic               cmp_en_q,    cmp_en_d;
    logic [15:0]        cmp_idx_q,   cmp_idx_d;
    logic [ERR_W-1:0]   err_q,       err_d;
    logic [15:0]        first_err_q, first_err_d;
    logic [LATENCY-1:0] pipe_q,      pipe_d;

    logic state_busy;
    logic start_ok;
    logic lfsr_fb;
    logic mismatch;

    assign state_busy = (state_q == ST_WARMUP) || (state_q == ST_RUN);

    // The FSM enters DONE one cycle before the last compare becomes visible,
    // so busy_q is still high then; blocking start on busy_q makes a start
    // that coincides with the final RUN cycle a no-op.
    assign start_ok = bus.start && !busy_q &&
                      ((state_q == ST_IDLE) || (state_q == ST_DONE));

    // x^16 + x^14 + x^13 + x^11 + 1, shifting towards the MSB.
    assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

    assign mismatch = cmp_en_q && (bus.result != pipe_q[LATENCY-1]);

    // -----------------------------------------------------------------------
    // Sequencing FSM
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_ok) begin
                    state_d = ST_WARMUP;
                    phase_d = 16'd0;
                end
            end
            ST_WARMUP: begin
                if (phase_q == WARM_LAST) begin
                    state_d = ST_RUN;
                    phase_d = 16'd0;
                end else begin
                    phase_d = phase_q + 16'd1;
                end
            end
            ST_RUN: begin
                if (phase_q == RUN_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    phase_d = phase_q + 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                phase_d = 16'd0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Stimulus generator and registered status outputs
    // -----------------------------------------------------------------------
    always_comb begin
        lfsr_d = lfsr_q;
        if (start_ok) begin
            lfsr_d = SEED;
        end else if (state_busy) begin
            lfsr_d = {lfsr_q[14:0], lfsr_fb};
        end
    end

    always_comb begin
        value_d   = state_busy ? lfsr_q[15] : 1'b0;
        busy_d    = state_busy;
        done_d    = (state_q == ST_DONE) && !start_ok;
        // Compare enable and RUN index trail the FSM by one cycle so that
        // they line up with the registered stimulus.
        cmp_en_d  = (state_q == ST_RUN);
        cmp_idx_d = phase_q;
    end

    // -----------------------------------------------------------------------
    // Expected pipe: one flop per cycle of harness latency. Shifts only while
    // the stimulus is live so the tail always holds value from LATENCY busy
    // cycles ago.
    // -----------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < LATENCY; gi++) begin : g_pipe
            if (gi == 0) begin : g_head
                assign pipe_d[gi] = start_ok ? 1'b0 :
                                    busy_q   ? value_q :
                                               pipe_q[gi];
            end else begin : g_body
                assign pipe_d[gi] = start_ok ? 1'b0 :
                                    busy_q   ? pipe_q[gi-1] :
                                               pipe_q[gi];
            end
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Checker: saturating error count and first failing RUN index
    // -----------------------------------------------------------------------
    always_comb begin
        err_d       = err_q;
        first_err_d = first_err_q;
        if (start_ok) begin
            err_d       = '0;
            first_err_d = NO_ERR;
        end else if (mismatch) begin
            if (err_q != ERR_MAX) begin
                err_d = err_q + ERR_ONE;
            end
            if (first_err_q == NO_ERR) begin
                first_err_d = cmp_idx_q;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            phase_q     <= 16'd0;
            lfsr_q      <= SEED;
            value_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cmp_en_q    <= 1'b0;
            cmp_idx_q   <= 16'd0;
            err_q       <= '0;
            first_err_q <= NO_ERR;
            pipe_q      <= '0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            lfsr_q      <= lfsr_d;
            value_q     <= value_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cmp_en_q    <= cmp_en_d;
            cmp_idx_q   <= cmp_idx_d;
            err_q       <= err_d;
            first_err_q <= first_err_d;
            pipe_q      <= pipe_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign bus.value           = value_q;
    assign bus.busy            = busy_q;
    assign bus.done            = done_q;
    assign bus.pass            = done_q && (err_q == '0);
    assign bus.err_count       = err_q;
    assign bus.first_err_cycle = first_err_q;

endmodule

// File: tb/tb_genit_stim.sv
// ---------------------------------------------------------------------------
// tb_genit_stim
//
// Two genit_stim instances run side by side: one with the default
// configuration (LATENCY=1, NUM_CYCLES=100, ERR_W=8) and one with
// LATENCY=3, NUM_CYCLES=100, ERR_W=4 for the saturating-counter case.
// The bench plays the harness (a LATENCY-cycle delay of `value`, optionally
// corrupted) and keeps a run-timeline model per instance: with t counting
// edges since start was taken, busy is high for t=1..L+N, value is the
// t-1'th bit of the expected stream, RUN index t-1-L is compared in cycle t,
// and done is high from t=L+N+1.
// ---------------------------------------------------------------------------
module tb_genit_stim;

    localparam int          L0   = 1;
    localparam int          NC0  = 100;
    localparam int          EW0  = 8;
    localparam int          L1   = 3;
    localparam int          NC1  = 100;
    localparam int          EW1  = 4;
    localparam logic [15:0] SEED = 16'hACE1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    genit_stim_if #(.ERR_W(EW0)) if0 ();
    genit_stim_if #(.ERR_W(EW1)) if1 ();

    genit_stim #(.LATENCY(L0), .NUM_CYCLES(NC0), .SEED(SEED), .ERR_W(EW0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0.master)
    );

    genit_stim #(.LATENCY(L1), .NUM_CYCLES(NC1), .SEED(SEED), .ERR_W(EW1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1.master)
    );

    // Model / harness state per instance
    int       lat      [2] = '{L0, L1};
    int       ncy      [2] = '{NC0, NC1};
    int       emax     [2] = '{255, 15};
    bit       started  [2];
    int       t        [2];
    int       m_err    [2];
    int       m_ferr   [2];
    bit [7:0] dl       [2];
    int       mode     [2];   // 0 loopback, 1 inverted, 2 flip one index, 3 random flips
    int       flip_idx [2];
    bit       start_req[2];
    bit       drv_start[2];
    bit       drv_res  [2];
    int       busy_cnt [2];

    bit          stream [0:255];
    logic [15:0] seed_lit;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input int d, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s dut%0d t=%0d: got %0d, expected %0d", name, d, t[d], act, exp);
        end
    endtask

    task automatic sample(input int d, output int v, output int b, output int dn,
                          output int p, output int e, output int f);
        if (d == 0) begin
            v = int'(if0.value); b = int'(if0.busy); dn = int'(if0.done);
            p = int'(if0.pass);  e = int'(if0.err_count); f = int'(if0.first_err_cycle);
        end else begin
            v = int'(if1.value); b = int'(if1.busy); dn = int'(if1.done);
            p = int'(if1.pass);  e = int'(if1.err_count); f = int'(if1.first_err_cycle);
        end
    endtask

    function automatic bit in_run(input int d);
        return started[d] && (t[d] >= lat[d] + 1) && (t[d] <= lat[d] + ncy[d]);
    endfunction

    // One clock cycle: drive at #1 after posedge, check and advance the model
    // at the negedge, return at #1 after the next posedge.
    task automatic step();
        int  v, b, dn, p, e, f, r;
        bit  inj, e_busy, e_done, e_val, mism;
        for (int d = 0; d < 2; d++) begin
            drv_start[d] = start_req[d];
            start_req[d] = 1'b0;
            r   = t[d] - 1 - lat[d];
            inj = 1'b0;
            case (mode[d])
                1:       inj = 1'b1;
                2:       inj = in_run(d) && (r == flip_idx[d]);
                3:       inj = ($urandom_range(0, 15) == 0);
                default: inj = 1'b0;
            endcase
            drv_res[d] = dl[d][lat[d]-1] ^ inj;
        end
        if0.start  = drv_start[0];
        if0.result = drv_res[0];
        if1.start  = drv_start[1];
        if1.result = drv_res[1];

        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            sample(d, v, b, dn, p, e, f);
            e_busy = started[d] && (t[d] >= 1) && (t[d] <= lat[d] + ncy[d]);
            e_done = started[d] && (t[d] >= lat[d] + ncy[d] + 1);
            e_val  = e_busy ? stream[t[d]-1] : 1'b0;
            check("busy",      d, b,  int'(e_busy));
            check("done",      d, dn, int'(e_done));
            check("value",     d, v,  int'(e_val));
            check("err_count", d, e,  m_err[d]);
            check("first_err", d, f,  m_ferr[d]);
            check("pass",      d, p,  int'(e_done && (m_err[d] == 0)));
            check("busy_and_done", d, b & dn, 0);
            if (b == 1) busy_cnt[d]++;
            // Pin the expected stream to the known first 16 seed bits.
            if (started[d] && t[d] >= 1 && t[d] <= 16)
                check("seed_bit", d, v, int'(seed_lit[16 - t[d]]));

            if (in_run(d)) begin
                r    = t[d] - 1 - lat[d];
                mism = (drv_res[d] != stream[r]);
                if (mism) begin
                    if (m_err[d] < emax[d]) m_err[d]++;
                    if (m_ferr[d] == 16'hFFFF) m_ferr[d] = r;
                end
            end
            dl[d] = {dl[d][6:0], v[0]};
            if (rst_n) begin
                if (drv_start[d] && (!started[d] || t[d] >= lat[d] + ncy[d] + 1)) begin
                    started[d]  = 1'b1;
                    t[d]        = 0;
                    m_err[d]    = 0;
                    m_ferr[d]   = 16'hFFFF;
                    busy_cnt[d] = 0;
                end else if (started[d] && t[d] < 100000) begin
                    t[d]++;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            started[d] = 1'b0;
            t[d]       = 0;
            m_err[d]   = 0;
            m_ferr[d]  = 16'hFFFF;
        end
        repeat (n) step();
        rst_n = 1'b1;
    endtask

    task automatic wait_t(input int d, input int target, input int budget);
        bit reached;
        reached = started[d] && (t[d] == target);
        for (int i = 0; i < budget && !reached; i++) begin
            step();
            reached = started[d] && (t[d] == target);
        end
        n_cmp++;
        if (!reached) begin
            n_fail++;
            $display("FAIL wait_t dut%0d: reached=%0d, required 1 (target t=%0d)", d, reached, target);
        end
    endtask

    task automatic report(input int d);
        int v, b, dn, p, e, f;
        sample(d, v, b, dn, p, e, f);
        $display("run dut%0d: done=%0d err_count=%0d first_err_cycle=%0d pass=%0d", d, dn, e, f, p);
    endtask

    initial begin
        logic [15:0] l;
        int v, b, dn, p, e, f;
        seed_lit = 16'b1010_1100_1110_0001;
        l = SEED;
        for (int i = 0; i < 256; i++) begin
            stream[i] = l[15];
            l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
        end
        for (int d = 0; d < 2; d++) begin
            started[d] = 0; t[d] = 0; m_err[d] = 0; m_ferr[d] = 16'hFFFF;
            dl[d] = '0; mode[d] = 0; flip_idx[d] = -1; start_req[d] = 0; busy_cnt[d] = 0;
        end
        if0.start = 0; if0.result = 0; if1.start = 0; if1.result = 0;
        @(posedge clk);
        #1;
        do_reset(3);
        step();

        // Run 1: clean loopback on dut0, inverted loopback on dut1.
        mode[0] = 0; mode[1] = 1;
        start_req[0] = 1; start_req[1] = 1;
        repeat (110) step();
        sample(0, v, b, dn, p, e, f);
        check("run1_done", 0, dn, 1);
        check("run1_err", 0, e, 0);
        check("run1_first", 0, f, 16'hFFFF);
        check("run1_pass", 0, p, 1);
        check("run1_busy_cycles", 0, busy_cnt[0], 101);
        sample(1, v, b, dn, p, e, f);
        check("sat_err", 1, e, 15);
        check("sat_first", 1, f, 0);
        check("sat_pass", 1, p, 0);
        check("sat_busy_cycles", 1, busy_cnt[1], 103);
        report(0); report(1);

        // Run 2: single flip at RUN index 37 on dut0; start pulses mid-RUN.
        mode[0] = 2; flip_idx[0] = 37; mode[1] = 0;
        start_req[0] = 1; start_req[1] = 1;
        step();
        wait_t(0, L0 + 1 + 20, 50);
        start_req[0] = 1; start_req[1] = 1;
        repeat (110) step();
        sample(0, v, b, dn, p, e, f);
        check("flip_err", 0, e, 1);
        check("flip_first", 0, f, 37);
        check("flip_pass", 0, p, 0);
        sample(1, v, b, dn, p, e, f);
        check("run2_pass", 1, p, 1);
        report(0); report(1);

        // Run 3: restart from DONE, then a start in the final RUN cycle.
        mode[0] = 0; mode[1] = 0;
        start_req[0] = 1; start_req[1] = 1;
        step();
        step(); step();
        sample(0, v, b, dn, p, e, f);
        check("restart_err_cleared", 0, e, 0);
        check("restart_done_cleared", 0, dn, 0);
        wait_t(0, L0 + NC0, 150);
        start_req[0] = 1;
        repeat (5) step();
        sample(0, v, b, dn, p, e, f);
        check("late_start_done", 0, dn, 1);
        check("late_start_busy", 0, b, 0);
        check("late_start_pass", 0, p, 1);
        repeat (5) step();
        report(0); report(1);

        // Run 4: reset at RUN index 50, then a fresh run.
        start_req[0] = 1; start_req[1] = 1;
        step();
        wait_t(0, L0 + 1 + 50, 100);
        do_reset(2);
        sample(0, v, b, dn, p, e, f);
        check("post_reset_busy", 0, b, 0);
        check("post_reset_first", 0, f, 16'hFFFF);
        step();
        start_req[0] = 1; start_req[1] = 1;
        repeat (110) step();
        sample(0, v, b, dn, p, e, f);
        check("rerun_pass", 0, p, 1);
        sample(1, v, b, dn, p, e, f);
        check("rerun_pass", 1, p, 1);
        report(0); report(1);

        // Randomized rounds: random result corruption and random start pulses.
        mode[0] = 3; mode[1] = 3;
        for (int round = 0; round < 6; round++) begin
            start_req[0] = 1; start_req[1] = 1;
            for (int i = 0; i < 130; i++) begin
                step();
                start_req[0] = ($urandom_range(0, 39) == 0);
                start_req[1] = ($urandom_range(0, 39) == 0);
            end
            report(0); report(1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
